// File: rtl/xml_stream_arbiter.sv
// xml_stream_arbiter
// Shares a single XML decoder between N byte-stream requesters. Owners are
// chosen round-robin, one message at a time. Each message is framed for the
// decoder as follows:
//   1. a newMsg pulse,
//   2. the granted lane's bytes,
//   3. a drain window after which the decoder's tag depth is checked for balance.
// Completion, length and error status are reported with a one-cycle msg_done pulse.
module xml_stream_arbiter #(
    parameter int N       = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 255,
    parameter int DRAIN   = 4
) (
    input  logic             CLOCK,
    input  logic             reset,
    input  logic [N-1:0]     req_valid,
    input  logic [8*N-1:0]   req_data,
    input  logic [N-1:0]     req_last,
    output logic [N-1:0]     req_ready,
    output logic [7:0]       dec_in,
    output logic             dec_inValid,
    output logic             dec_newMsg,
    input  logic [3:0]       dec_tagDepth,
    output logic [IDW-1:0]   grant_id,
    output logic             busy,
    output logic             msg_done,
    output logic [1:0]       msg_err,
    output logic [15:0]      msg_len
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_STREAM = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // The stall counter aborts when it already holds TIMEOUT-1 and yet another
    // idle cycle passes, i.e. on the TIMEOUT-th consecutive idle cycle.
    localparam logic [15:0] STALL_LIMIT = 16'(TIMEOUT - 1);
    localparam logic [3:0]  DRAIN_LAST  = 4'(DRAIN - 1);
    localparam logic [15:0] LEN_MAX     = 16'hFFFF;

    logic [2:0]     state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic [15:0]    len_q, len_d;
    logic [15:0]    stall_q, stall_d;
    logic [3:0]     drain_q, drain_d;
    logic           timeout_q, timeout_d;
    logic [7:0]     dec_in_q, dec_in_d;
    logic           dec_valid_q, dec_valid_d;
    logic           new_msg_q, new_msg_d;
    logic           done_q, done_d;
    logic [1:0]     err_q, err_d;
    logic [15:0]    msg_len_q, msg_len_d;

    logic           arb_found;
    logic [IDW-1:0] arb_pick;
    logic [7:0]     lane_byte;
    logic           lane_valid;
    logic           lane_last;
    logic           transfer;

    // Lane index reached by stepping 'step' positions past 'base', wrapping at N.
    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int step);
        return IDW'((int'(base) + step) % N);
    endfunction

    assign lane_byte  = req_data[8*int'(grant_q) +: 8];
    assign lane_valid = req_valid[grant_q];
    assign lane_last  = req_last[grant_q];
    assign transfer   = (state_q == ST_STREAM) && lane_valid;

    // Round-robin search: first requesting lane after the previous owner, with wrap-around.
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = '0;
        for (int k = 1; k <= N; k++) begin
            if (!arb_found && req_valid[rr_index(last_grant_q, k)]) begin
                arb_found = 1'b1;
                arb_pick  = rr_index(last_grant_q, k);
            end
        end
    end

    // Only the owner sees ready, and only while its bytes are being streamed.
    always_comb begin
        req_ready = '0;
        if (state_q == ST_STREAM) begin
            req_ready[grant_q] = 1'b1;
        end
    end

    // Message framing FSM. Computes the next value of every register.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        len_d        = len_q;
        stall_d      = stall_q;
        drain_d      = drain_q;
        timeout_d    = timeout_q;
        dec_in_d     = dec_in_q;
        dec_valid_d  = 1'b0;
        new_msg_d    = 1'b0;
        done_d       = 1'b0;
        err_d        = err_q;
        msg_len_d    = msg_len_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_found) begin
                    grant_d   = arb_pick;
                    len_d     = '0;
                    stall_d   = '0;
                    drain_d   = '0;
                    timeout_d = 1'b0;
                    state_d   = ST_START;
                end
            end

            ST_START: begin
                // newMsg is registered like the byte path, so the decoder sees
                // it exactly one cycle ahead of the earliest possible byte.
                new_msg_d = 1'b1;
                state_d   = ST_STREAM;
            end

            ST_STREAM: begin
                if (transfer) begin
                    dec_in_d    = lane_byte;
                    dec_valid_d = 1'b1;
                    stall_d     = '0;
                    if (len_q != LEN_MAX) begin
                        len_d = len_q + 16'd1;
                    end
                    if (lane_last) begin
                        drain_d = '0;
                        state_d = ST_DRAIN;
                    end
                end else if (stall_q >= STALL_LIMIT) begin
                    // Bytes already forwarded stay with the decoder; only the
                    // timeout flag records the abort.
                    timeout_d = 1'b1;
                    drain_d   = '0;
                    state_d   = ST_DRAIN;
                end else begin
                    stall_d = stall_q + 16'd1;
                end
            end

            ST_DRAIN: begin
                if (drain_q >= DRAIN_LAST) begin
                    done_d    = 1'b1;
                    err_d     = {(dec_tagDepth != 4'd0), timeout_q};
                    msg_len_d = len_q;
                    state_d   = ST_DONE;
                end else begin
                    drain_d = drain_q + 4'd1;
                end
            end

            ST_DONE: begin
                last_grant_d = grant_q;
                state_d      = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers. Reset abandons any message in flight silently.
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDW'(N - 1);
            len_q        <= '0;
            stall_q      <= '0;
            drain_q      <= '0;
            timeout_q    <= 1'b0;
            dec_in_q     <= '0;
            dec_valid_q  <= 1'b0;
            new_msg_q    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= '0;
            msg_len_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            len_q        <= len_d;
            stall_q      <= stall_d;
            drain_q      <= drain_d;
            timeout_q    <= timeout_d;
            dec_in_q     <= dec_in_d;
            dec_valid_q  <= dec_valid_d;
            new_msg_q    <= new_msg_d;
            done_q       <= done_d;
            err_q        <= err_d;
            msg_len_q    <= msg_len_d;
        end
    end

    assign dec_in      = dec_in_q;
    assign dec_inValid = dec_valid_q;
    assign dec_newMsg  = new_msg_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q != ST_IDLE);
    assign msg_done    = done_q;
    assign msg_err     = err_q;
    assign msg_len     = msg_len_q;

endmodule

// File: tb/tb_xml_stream_arbiter.sv
// Bench for xml_stream_arbiter: lane drivers feed messages, a small decoder
// model drives tagDepth, and scoreboards hold the expected byte stream and
// per-message completion reports.
module tb_xml_stream_arbiter;

    localparam int N       = 4;
    localparam int IDW     = 2;
    localparam int TIMEOUT = 8;
    localparam int DRAIN   = 4;

    typedef struct {
        int lane;
        int len;
        int err;
        int gap;
    } expMsgT;

    logic             CLOCK;
    logic             reset;
    logic [N-1:0]     reqValid;
    logic [8*N-1:0]   reqData;
    logic [N-1:0]     reqLast;
    logic [N-1:0]     req_ready;
    logic [7:0]       dec_in;
    logic             dec_inValid;
    logic             dec_newMsg;
    logic [3:0]       depthModel;
    logic [IDW-1:0]   grant_id;
    logic             busy;
    logic             msg_done;
    logic [1:0]       msg_err;
    logic [15:0]      msg_len;

    logic             laneValid [N];
    logic [7:0]       laneData  [N];
    logic             laneLast  [N];

    expMsgT           expQ[$];
    logic [7:0]       expBytes[$];
    expMsgT           curMsg;
    logic [7:0]       curByte;
    int               totalChecks;
    int               badChecks;
    int               cycleCount;
    int               lastValidCycle;
    logic             newMsgPrev;
    logic             sawLt;
    logic             ignoreBytes;

    xml_stream_arbiter #(
        .N(N), .IDW(IDW), .TIMEOUT(TIMEOUT), .DRAIN(DRAIN)
    ) dut (
        .CLOCK(CLOCK),
        .reset(reset),
        .req_valid(reqValid),
        .req_data(reqData),
        .req_last(reqLast),
        .req_ready(req_ready),
        .dec_in(dec_in),
        .dec_inValid(dec_inValid),
        .dec_newMsg(dec_newMsg),
        .dec_tagDepth(depthModel),
        .grant_id(grant_id),
        .busy(busy),
        .msg_done(msg_done),
        .msg_err(msg_err),
        .msg_len(msg_len)
    );

    for (genvar g = 0; g < N; g++) begin : gLanes
        assign reqValid[g]          = laneValid[g];
        assign reqData[8*g +: 8]    = laneData[g];
        assign reqLast[g]           = laneLast[g];
    end

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cycleCount <= cycleCount + 1;

    // Decoder stand-in: '<' followed by '/' closes a tag, '<' followed by anything else opens one.
    always @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            depthModel <= 4'd0;
            sawLt      <= 1'b0;
        end else if (dec_newMsg) begin
            depthModel <= 4'd0;
            sawLt      <= 1'b0;
        end else if (dec_inValid) begin
            if (sawLt && dec_in == 8'h2F) begin
                if (depthModel != 4'd0) depthModel <= depthModel - 4'd1;
            end else if (sawLt) begin
                depthModel <= depthModel + 4'd1;
            end
            sawLt <= (dec_in == 8'h3C);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        totalChecks++;
        if (actual !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Queue the completion report and the bytes the decoder should receive for one message.
    task automatic expectMessage(input int lane, input string msg, input int nBytes, input int err, input int gap);
        expMsgT e;
        e.lane = lane;
        e.len  = nBytes;
        e.err  = err;
        e.gap  = gap;
        expQ.push_back(e);
        for (int i = 0; i < nBytes; i++) expBytes.push_back(msg[i]);
    endtask

    // Drive one message on a lane; gapCycles idle cycles between bytes, stop early after stopAfter bytes.
    task automatic applyStimulus(input int lane, input string msg, input int gapCycles, input int stopAfter);
        int waitCount;
        bit accepted;
        for (int i = 0; i < msg.len(); i++) begin
            if (i == stopAfter) break;
            laneValid[lane] = 1'b1;
            laneData[lane]  = msg[i];
            laneLast[lane]  = (i == msg.len() - 1);
            waitCount = 0;
            accepted  = 1'b0;
            while (!accepted) begin
                @(negedge CLOCK);
                if (req_ready[lane]) begin
                    accepted = 1'b1;
                end else if (++waitCount > 2000) begin
                    checkOutput("handshake_bound", 32'(lane), 32'hFFFF);
                    laneValid[lane] = 1'b0;
                    laneLast[lane]  = 1'b0;
                    return;
                end
            end
            @(posedge CLOCK);
            #1;
            laneValid[lane] = 1'b0;
            laneLast[lane]  = 1'b0;
            if (gapCycles > 0 && i < msg.len() - 1) begin
                repeat (gapCycles) @(posedge CLOCK);
                #1;
            end
        end
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((expQ.size() != 0 || busy) && n < 1000) begin
            @(negedge CLOCK);
            n++;
        end
        @(negedge CLOCK);
        checkOutput("idle_reached", 32'(n < 1000), 32'd1);
    endtask

    // Byte and framing monitor, sampled on the falling edge.
    always @(negedge CLOCK) begin
        if (reset) begin
            newMsgPrev <= 1'b0;
        end else begin
            newMsgPrev <= dec_newMsg;
            if (dec_newMsg) checkOutput("newmsg_valid_low", 32'(dec_inValid), 32'd0);
            if (newMsgPrev) checkOutput("first_byte_after_newmsg", 32'(dec_inValid), 32'd1);
            if (dec_inValid) begin
                lastValidCycle <= cycleCount;
                if (!ignoreBytes) begin
                    if (expBytes.size() == 0) begin
                        checkOutput("extra_byte", 32'(dec_in), 32'hFFFF);
                    end else begin
                        curByte = expBytes.pop_front();
                        checkOutput("dec_in", 32'(dec_in), 32'(curByte));
                    end
                end
            end
            if (msg_done) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_msg_done", 32'd1, 32'd0);
                end else begin
                    curMsg = expQ.pop_front();
                    checkOutput("grant_id", 32'(grant_id), 32'(curMsg.lane));
                    checkOutput("msg_len", 32'(msg_len), 32'(curMsg.len));
                    checkOutput("msg_err", 32'(msg_err), 32'(curMsg.err));
                    checkOutput("drain_gap", 32'(cycleCount - lastValidCycle), 32'(curMsg.gap));
                end
            end
        end
    end

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        checkOutput({tag, "_dec_in"}, 32'(dec_in), 32'd0);
        checkOutput({tag, "_dec_inValid"}, 32'(dec_inValid), 32'd0);
        checkOutput({tag, "_dec_newMsg"}, 32'(dec_newMsg), 32'd0);
        checkOutput({tag, "_grant_id"}, 32'(grant_id), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_msg_done"}, 32'(msg_done), 32'd0);
        checkOutput({tag, "_msg_err"}, 32'(msg_err), 32'd0);
        checkOutput({tag, "_msg_len"}, 32'(msg_len), 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        totalChecks    = 0;
        badChecks      = 0;
        cycleCount     = 0;
        lastValidCycle = 0;
        ignoreBytes    = 1'b0;
        for (int i = 0; i < N; i++) begin
            laneValid[i] = 1'b0;
            laneData[i]  = 8'h00;
            laneLast[i]  = 1'b0;
        end
        reset = 1'b1;
        repeat (3) @(posedge CLOCK);
        #1;
        checkAllZero("reset");
        @(negedge CLOCK);
        reset = 1'b0;

        // Single balanced message on lane 0.
        $display("[TB] single message");
        expectMessage(0, "<a></a>", 7, 0, DRAIN);
        applyStimulus(0, "<a></a>", 0, 99);
        waitIdle();
        checkOutput("msg_len_hold", 32'(msg_len), 32'd7);
        checkOutput("grant_hold", 32'(grant_id), 32'd0);

        // Round robin: 1 and 3 together, then 0 and 1 together.
        $display("[TB] round robin");
        expectMessage(1, "<b></b>", 7, 0, DRAIN);
        expectMessage(3, "<c></c>", 7, 0, DRAIN);
        fork
            applyStimulus(1, "<b></b>", 0, 99);
            applyStimulus(3, "<c></c>", 0, 99);
        join
        waitIdle();
        expectMessage(0, "<d></d>", 7, 0, DRAIN);
        expectMessage(1, "<e></e>", 7, 0, DRAIN);
        fork
            applyStimulus(1, "<e></e>", 0, 99);
            applyStimulus(0, "<d></d>", 0, 99);
        join
        waitIdle();

        // Timeout: three bytes, then the lane goes quiet.
        $display("[TB] timeout");
        expectMessage(2, "abc", 3, 1, TIMEOUT + DRAIN);
        applyStimulus(2, "abcdef", 0, 3);
        waitIdle();
        checkOutput("ready2_after_timeout", 32'(req_ready[2]), 32'd0);

        // Unbalanced tags, then a balanced message on the same lane.
        $display("[TB] unbalanced");
        expectMessage(2, "<a><b></a>", 10, 2, DRAIN);
        applyStimulus(2, "<a><b></a>", 0, 99);
        waitIdle();
        expectMessage(2, "<a></a>", 7, 0, DRAIN);
        applyStimulus(2, "<a></a>", 0, 99);
        waitIdle();

        // Gaps just under the timeout must not abort.
        $display("[TB] stalls under timeout");
        expectMessage(1, "<f></f>", 7, 0, DRAIN);
        applyStimulus(1, "<f></f>", TIMEOUT - 1, 99);
        waitIdle();

        // Asynchronous reset in the middle of a stream.
        $display("[TB] reset mid-stream");
        ignoreBytes   = 1'b1;
        laneValid[3]  = 1'b1;
        laneData[3]   = 8'h3C;
        laneLast[3]   = 1'b0;
        n = 0;
        while (!busy && n < 100) begin
            @(negedge CLOCK);
            n++;
        end
        repeat (5) @(negedge CLOCK);
        checkOutput("lane3_streaming", 32'({busy, grant_id}), 32'({1'b1, 2'd3}));
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("async_reset");
        laneValid[3] = 1'b0;
        @(negedge CLOCK);
        reset       = 1'b0;
        ignoreBytes = 1'b0;
        expectMessage(1, "<g></g>", 7, 0, DRAIN);
        expectMessage(3, "<h></h>", 7, 0, DRAIN);
        fork
            applyStimulus(1, "<g></g>", 0, 99);
            applyStimulus(3, "<h></h>", 0, 99);
        join
        waitIdle();
        checkOutput("bytes_all_consumed", 32'(expBytes.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
